// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Pipelined RV32I/RV64I instruction-decode stage between fetch and execute.
// One instruction per cycle is accepted over a valid/ready handshake. It is
// fully decoded into control fields, register indices and a sign-extended
// immediate, and the result is held in an output register. A load-use
// interlock inserts a single bubble when the incoming instruction reads the
// destination of a load that is still sitting in the output register.
//
// Optional feature macro: DECODE_MULDIV_EN
//   defined   : OP with funct7=0000001 decodes the M extension
//               (aluOp = 10_funct3, legal, writes rd).
//   undefined : those encodings are illegal and aluOp[4] is always 0.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   flush                 drop the held bundle and the incoming instruction
//   in_valid / in_ready   fetch-side handshake
//   in_instr, in_pc       raw instruction and its address
//   out_valid / out_ready execute-side handshake
//   out_pc                registered pc
//   out_rs1/rs2/rd        register indices (rd is 0 when nothing is written)
//   out_imm               sign-extended I/S/B/U/J immediate
//   out_memWrite, out_regWrite, out_memToReg, out_branch, out_jump
//   out_aluSrc            1 selects rs2 as ALU operand B, 0 selects imm
//   out_aluA_pc           ALU operand A is the pc (AUIPC, JAL)
//   out_aluOp             ALU operation code
//   out_funct3            funct3 pass-through (branch cond, load/store size)
//   out_illegal           encoding not supported
//   stall_cnt             saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_memWrite,
    output logic            out_regWrite,
    output logic            out_memToReg,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_aluSrc,
    output logic            out_aluA_pc,
    output logic [4:0]      out_aluOp,
    output logic [2:0]      out_funct3,
    output logic            out_illegal,
    output logic [15:0]     stall_cnt
);

`ifdef DECODE_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    // Opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_PASB = 5'b00010;
    localparam logic [4:0] ALU_SLT  = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b00100;
    localparam logic [4:0] ALU_SLL  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b01001;
    localparam logic [4:0] ALU_XOR  = 5'b01010;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [4:0] rd_f;
    logic [6:0] shift_f7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign rd_f   = in_instr[11:7];

    // On RV64 the shift amount is six bits wide, so instr[25] belongs to
    // shamt and must be ignored when validating the shift funct7.
    assign shift_f7 = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

    // Decoded next-state values
    logic        reg_write_d;
    logic        mem_write_d;
    logic        mem_to_reg_d;
    logic        branch_d;
    logic        jump_d;
    logic        alu_src_d;
    logic        alu_a_pc_d;
    logic [4:0]  alu_op_d;
    logic        illegal_d;
    logic [4:0]  rd_d;
    logic [31:0] imm32_d;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [XLEN-1:0] imm_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        alu_src_d    = 1'b0;
        alu_a_pc_d   = 1'b0;
        alu_op_d     = ALU_ADD;
        illegal_d    = 1'b0;
        imm32_d      = 32'd0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;

        case (opcode)
            OPC_LUI: begin
                reg_write_d = 1'b1;
                alu_op_d    = ALU_PASB;
                imm32_d     = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                reg_write_d = 1'b1;
                alu_a_pc_d  = 1'b1;
                imm32_d     = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                reg_write_d = 1'b1;
                jump_d      = 1'b1;
                alu_a_pc_d  = 1'b1;
                imm32_d     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                reg_write_d = 1'b1;
                jump_d      = 1'b1;
                uses_rs1    = 1'b1;
                imm32_d     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_BRANCH: begin
                branch_d  = 1'b1;
                alu_src_d = 1'b1;
                alu_op_d  = ALU_SUB;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm32_d   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            OPC_LOAD: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                uses_rs1     = 1'b1;
                imm32_d      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                mem_write_d = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                imm32_d     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_OPIMM: begin
                reg_write_d = 1'b1;
                uses_rs1    = 1'b1;
                imm32_d     = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: alu_op_d = ALU_ADD;
                    3'b010: alu_op_d = ALU_SLT;
                    3'b011: alu_op_d = ALU_SLTU;
                    3'b100: alu_op_d = ALU_XOR;
                    3'b110: alu_op_d = ALU_OR;
                    3'b111: alu_op_d = ALU_AND;
                    3'b001: begin
                        alu_op_d = ALU_SLL;
                        if (shift_f7 != 7'b0000000) illegal_d = 1'b1;
                    end
                    default: begin // 3'b101
                        if (shift_f7 == 7'b0000000)      alu_op_d = ALU_SRL;
                        else if (shift_f7 == 7'b0100000) alu_op_d = ALU_SRA;
                        else                             illegal_d = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                if (MULDIV_EN && funct7 == 7'b0000001) begin
                    alu_op_d = {2'b10, funct3};
                end else begin
                    case ({funct7, funct3})
                        10'b0000000_000: alu_op_d = ALU_ADD;
                        10'b0100000_000: alu_op_d = ALU_SUB;
                        10'b0000000_001: alu_op_d = ALU_SLL;
                        10'b0000000_010: alu_op_d = ALU_SLT;
                        10'b0000000_011: alu_op_d = ALU_SLTU;
                        10'b0000000_100: alu_op_d = ALU_XOR;
                        10'b0000000_101: alu_op_d = ALU_SRL;
                        10'b0100000_101: alu_op_d = ALU_SRA;
                        10'b0000000_110: alu_op_d = ALU_OR;
                        10'b0000000_111: alu_op_d = ALU_AND;
                        default:         illegal_d = 1'b1;
                    endcase
                end
            end
            default: illegal_d = 1'b1;
        endcase

        // Illegal encodings still flow down the pipe but must not cause
        // any architectural side effect.
        if (illegal_d) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            alu_op_d     = ALU_ADD;
        end
    end

    assign rd_d = reg_write_d ? rd_f : 5'd0;

    // Sign-extend the 32-bit immediate to XLEN (empty loop when XLEN=32).
    assign imm_d[31:0] = imm32_d;
    for (genvar gi = 32; gi < XLEN; gi++) begin : g_imm_ext
        assign imm_d[gi] = imm32_d[31];
    end

    // Output register
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] imm_q;
    logic            mem_write_q;
    logic            reg_write_q;
    logic            mem_to_reg_q;
    logic            branch_q;
    logic            jump_q;
    logic            alu_src_q;
    logic            alu_a_pc_q;
    logic [4:0]      alu_op_q;
    logic [2:0]      funct3_q;
    logic            illegal_q;
    logic [15:0]     stall_cnt_q;

    // Load-use hazard: the held load writes a register that the incoming
    // instruction reads, so the consumer must wait one cycle.
    logic hazard;
    logic accept;

    assign hazard = valid_q && mem_to_reg_q && (rd_q != 5'd0) && in_valid &&
                    ((uses_rs1 && (rs1_f == rd_q)) || (uses_rs2 && (rs2_f == rd_q)));
    assign in_ready = (!valid_q || out_ready) && !hazard && !reset;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            imm_q        <= '0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_a_pc_q   <= 1'b0;
            alu_op_q     <= 5'd0;
            funct3_q     <= 3'd0;
            illegal_q    <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else if (flush) begin
            // Redirect: kill held and incoming; no bubble is counted.
            valid_q <= 1'b0;
        end else if (hazard) begin
            // Hold the load while execute is stalled; once it drains,
            // replace it with a bubble.
            if (out_ready) begin
                valid_q <= 1'b0;
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_q <= stall_cnt_q + 16'd1;
                end
            end
        end else if (accept) begin
            valid_q      <= 1'b1;
            pc_q         <= in_pc;
            rs1_q        <= rs1_f;
            rs2_q        <= rs2_f;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            alu_src_q    <= alu_src_d;
            alu_a_pc_q   <= alu_a_pc_d;
            alu_op_q     <= alu_op_d;
            funct3_q     <= funct3;
            illegal_q    <= illegal_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_imm      = imm_q;
    assign out_memWrite = mem_write_q;
    assign out_regWrite = reg_write_q;
    assign out_memToReg = mem_to_reg_q;
    assign out_branch   = branch_q;
    assign out_jump     = jump_q;
    assign out_aluSrc   = alu_src_q;
    assign out_aluA_pc  = alu_a_pc_q;
    assign out_aluOp    = alu_op_q;
    assign out_funct3   = funct3_q;
    assign out_illegal  = illegal_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed testbench for decode_stage (XLEN=32). Each task drives one
// scenario and checks outputs against hand-computed values. Inputs change
// 1 ns after the rising edge; registered outputs are checked there too,
// and combinational in_ready is checked 1 ns after inputs settle.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam int XLEN = 32;

    localparam logic [31:0] I_ADDI   = 32'hFFD00293; // addi x5,x0,-3
    localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB    = 32'h40208233; // sub  x4,x1,x2
    localparam logic [31:0] I_XOR    = 32'h0020C2B3; // xor  x5,x1,x2
    localparam logic [31:0] I_SRA    = 32'h4020D333; // sra  x6,x1,x2
    localparam logic [31:0] I_LW6    = 32'h0000A303; // lw   x6,0(x1)
    localparam logic [31:0] I_ADD76  = 32'h002303B3; // add  x7,x6,x2
    localparam logic [31:0] I_LW0    = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD70  = 32'h002003B3; // add  x7,x0,x2
    localparam logic [31:0] I_LUI    = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] I_JAL    = 32'h008000EF; // jal  x1,+8
    localparam logic [31:0] I_BEQ    = 32'hFE208EE3; // beq  x1,x2,-4
    localparam logic [31:0] I_SW     = 32'hFE20AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_BAD    = 32'h0000007F; // unlisted opcode
    localparam logic [31:0] I_MUL    = 32'h023100B3; // mul  x1,x2,x3

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_memWrite;
    logic            out_regWrite;
    logic            out_memToReg;
    logic            out_branch;
    logic            out_jump;
    logic            out_aluSrc;
    logic            out_aluA_pc;
    logic [4:0]      out_aluOp;
    logic [2:0]      out_funct3;
    logic            out_illegal;
    logic [15:0]     stall_cnt;

    int checks = 0;
    int errors = 0;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_imm      (out_imm),
        .out_memWrite (out_memWrite),
        .out_regWrite (out_regWrite),
        .out_memToReg (out_memToReg),
        .out_branch   (out_branch),
        .out_jump     (out_jump),
        .out_aluSrc   (out_aluSrc),
        .out_aluA_pc  (out_aluA_pc),
        .out_aluOp    (out_aluOp),
        .out_funct3   (out_funct3),
        .out_illegal  (out_illegal),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per bundle consumed by execute.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            $display("xfer pc=%h aluOp=%b rd=%0d imm=%h ill=%0b stalls=%0d",
                     out_pc, out_aluOp, out_rd, out_imm, out_illegal, stall_cnt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h100;
        cyc(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h required 0", out_imm); end
        checks++; if (out_regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite: got %b required 0", out_regWrite); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h required 0", stall_cnt); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h required 0", out_pc); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b required 1", out_valid); end
        checks++; if (out_aluOp !== 5'b00000) begin errors++; $display("FAIL addi_aluOp: got %b required 00000", out_aluOp); end
        checks++; if (out_imm !== 32'hFFFFFFFD) begin errors++; $display("FAIL addi_imm: got %h required fffffffd", out_imm); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d required 5", out_rd); end
        checks++; if (out_regWrite !== 1'b1) begin errors++; $display("FAIL addi_regWrite: got %b required 1", out_regWrite); end
        checks++; if (out_aluSrc !== 1'b0) begin errors++; $display("FAIL addi_aluSrc: got %b required 0", out_aluSrc); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h required 100", out_pc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [4];
        logic [4:0]  ops    [4];
        logic [4:0]  rds    [4];
        instrs[0] = I_ADD; ops[0] = 5'b00000; rds[0] = 5'd3;
        instrs[1] = I_SUB; ops[1] = 5'b00001; rds[1] = 5'd4;
        instrs[2] = I_XOR; ops[2] = 5'b01010; rds[2] = 5'd5;
        instrs[3] = I_SRA; ops[3] = 5'b00111; rds[3] = 5'd6;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = instrs[i];
            in_pc    = 32'h200 + 32'(i * 4);
            cyc();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b required 1", i, out_valid); end
            checks++; if (out_aluOp !== ops[i]) begin errors++; $display("FAIL b2b_aluOp[%0d]: got %b required %b", i, out_aluOp, ops[i]); end
            checks++; if (out_rd !== rds[i]) begin errors++; $display("FAIL b2b_rd[%0d]: got %0d required %0d", i, out_rd, rds[i]); end
            checks++; if (out_aluSrc !== 1'b1) begin errors++; $display("FAIL b2b_aluSrc[%0d]: got %b required 1", i, out_aluSrc); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_LW6; in_pc = 32'h300;
        cyc();
        checks++; if (out_memToReg !== 1'b1) begin errors++; $display("FAIL lw_memToReg: got %b required 1", out_memToReg); end
        checks++; if (out_rd !== 5'd6) begin errors++; $display("FAIL lw_rd: got %0d required 6", out_rd); end
        checks++; if (out_funct3 !== 3'b010) begin errors++; $display("FAIL lw_funct3: got %b required 010", out_funct3); end
        in_instr = I_ADD76; in_pc = 32'h304;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready: got %b required 0", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b required 0", out_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL bubble_stall: got %0d required 1", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_bubble_in_ready: got %b required 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dep_add_valid: got %b required 1", out_valid); end
        checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL dep_add_rd: got %0d required 7", out_rd); end
        checks++; if (out_pc !== 32'h304) begin errors++; $display("FAIL dep_add_pc: got %h required 304", out_pc); end
        // Load to x0 never interlocks.
        in_instr = I_LW0; in_pc = 32'h308;
        cyc();
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL lw0_rd: got %0d required 0", out_rd); end
        in_instr = I_ADD70; in_pc = 32'h30C;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw0_no_hazard: got %b required 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw0_add_valid: got %b required 1", out_valid); end
        checks++; if (out_pc !== 32'h30C) begin errors++; $display("FAIL lw0_add_pc: got %h required 30c", out_pc); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lw0_stall: got %0d required 1", stall_cnt); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_LUI; in_pc = 32'h400;
        cyc();
        out_ready = 1'b0;
        in_instr = I_ADDI; in_pc = 32'h404;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
            cyc();
            checks++; if (out_imm !== 32'h12345000) begin errors++; $display("FAIL bp_imm[%0d]: got %h required 12345000", i, out_imm); end
            checks++; if (out_aluOp !== 5'b00010) begin errors++; $display("FAIL bp_aluOp[%0d]: got %b required 00010", i, out_aluOp); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b required 1", i, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        cyc();
        checks++; if (out_pc !== 32'h404) begin errors++; $display("FAIL bp_next_pc: got %h required 404", out_pc); end
        checks++; if (out_imm !== 32'hFFFFFFFD) begin errors++; $display("FAIL bp_next_imm: got %h required fffffffd", out_imm); end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_JAL; in_pc = 32'h500; flush = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", out_valid); end
        flush = 1'b0; in_instr = I_ADDI; in_pc = 32'h600;
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %b required 1", out_valid); end
        checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL post_flush_pc: got %h required 600", out_pc); end
        in_instr = I_JAL; in_pc = 32'h604;
        cyc();
        checks++; if (out_jump !== 1'b1) begin errors++; $display("FAIL jal_jump: got %b required 1", out_jump); end
        checks++; if (out_aluA_pc !== 1'b1) begin errors++; $display("FAIL jal_aluA_pc: got %b required 1", out_aluA_pc); end
        checks++; if (out_imm !== 32'h8) begin errors++; $display("FAIL jal_imm: got %h required 8", out_imm); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL jal_rd: got %0d required 1", out_rd); end
        // Flush coinciding with a load-use hazard: flush wins, no stall counted.
        in_instr = I_LW6; in_pc = 32'h608;
        cyc();
        in_instr = I_ADD76; in_pc = 32'h60C; flush = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hazard_valid: got %b required 0", out_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_hazard_stall: got %0d required 1", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_formats();
        logic [4:0] mul_op;
        logic       mul_ill;
        logic       mul_rw;
`ifdef DECODE_MULDIV_EN
        mul_op = 5'b10000; mul_ill = 1'b0; mul_rw = 1'b1;
`else
        mul_op = 5'b00000; mul_ill = 1'b1; mul_rw = 1'b0;
`endif
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = I_BEQ; in_pc = 32'h700;
        cyc();
        checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm: got %h required fffffffc", out_imm); end
        checks++; if (out_branch !== 1'b1) begin errors++; $display("FAIL beq_branch: got %b required 1", out_branch); end
        checks++; if (out_aluOp !== 5'b00001) begin errors++; $display("FAIL beq_aluOp: got %b required 00001", out_aluOp); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL beq_rd: got %0d required 0", out_rd); end
        in_instr = I_SW; in_pc = 32'h704;
        cyc();
        checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm: got %h required fffffffc", out_imm); end
        checks++; if (out_memWrite !== 1'b1) begin errors++; $display("FAIL sw_memWrite: got %b required 1", out_memWrite); end
        checks++; if (out_rs2 !== 5'd2) begin errors++; $display("FAIL sw_rs2: got %0d required 2", out_rs2); end
        in_instr = I_BAD; in_pc = 32'h708;
        cyc();
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL bad_illegal: got %b required 1", out_illegal); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_valid: got %b required 1", out_valid); end
        checks++; if (out_regWrite !== 1'b0) begin errors++; $display("FAIL bad_regWrite: got %b required 0", out_regWrite); end
        in_instr = I_MUL; in_pc = 32'h70C;
        cyc();
        checks++; if (out_aluOp !== mul_op) begin errors++; $display("FAIL mul_aluOp: got %b required %b", out_aluOp, mul_op); end
        checks++; if (out_illegal !== mul_ill) begin errors++; $display("FAIL mul_illegal: got %b required %b", out_illegal, mul_ill); end
        checks++; if (out_regWrite !== mul_rw) begin errors++; $display("FAIL mul_regWrite: got %b required %b", out_regWrite, mul_rw); end
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_flush();
        test_formats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I/RV64I instruction-decode stage that succeeds the single-cycle combinational decoder. It sits between the fetch stage and the execute stage. It accepts one instruction per cycle over a valid/ready handshake and fully decodes the base integer ISA, including immediates, shifts, XOR, LUI and AUIPC. Control fields, register indices and the sign-extended immediate are registered, with a built-in one-bubble load-use interlock.

## Interface
- XLEN, 32: datapath width; 32 or 64; sets pc/imm width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill held and incoming instruction (branch/jump redirect).
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  registered bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered pc.
- out_rs1, out_rs2, out_rd  out  5 each  register indices (rd forced 0 when regWrite=0).
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate.
- out_memWrite, out_regWrite, out_memToReg, out_branch, out_jump, out_aluSrc  out  1 each  same meaning as the existing control signals; aluSrc=1 selects rs2.
- out_aluA_pc  out  1  ALU operand A is pc (AUIPC, JAL).
- out_aluOp  out  5  ALU operation.
- out_funct3  out  3  passed through for branch condition and load/store size.
- out_illegal  out  1  unsupported encoding.
- stall_cnt  out  16  saturating count of load-use bubbles.

## Operation
- aluOp codes: add 00000, sub 00001, passB 00010, slt 00011, sltu 00100, sll 00101, srl 00110, sra 00111, or 01000, and 01001, xor 01010.
- Preselection:
  - B-type → sub.
  - Load/store/JAL/JALR/AUIPC → add.
  - LUI → passB.
  - OP-IMM → by funct3; funct7[5] selects sra for funct3=101.
  - OP → by {funct7,funct3}.
- Immediate formats:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended from bit 31 to XLEN.
- out_illegal=1 for an unlisted opcode, or an OP/OP-IMM funct7 not in the table. Such an instruction still passes through with all write/branch/jump controls forced 0.
- Load-use interlock:
  - Trigger: held bundle is valid, out_memToReg=1, out_rd≠0, and the incoming instruction reads that rd. rs1 counts when the opcode uses rs1; rs2 counts for OP, B and S.
  - Response: in_ready=0 for that cycle. If out_ready=1, a bubble (out_valid=0) is loaded and stall_cnt increments, saturating at 0xFFFF.
- Flush: on the next edge out_valid=0 and the incoming instruction is dropped, even if in_valid=1. Flush has priority over the interlock and over the handshake.

## Timing
- Latency: one cycle from accepted input to out_valid.
- in_ready = (!out_valid || out_ready) && !hazard && !reset.
- Throughput is one instruction per cycle when no hazard occurs.
- The bundle holds stable while out_valid && !out_ready.
- Accepted input = in_valid && in_ready. On acceptance the register loads and out_valid=1. If out_ready=1 and nothing is accepted, out_valid→0.
- Reset values:
  - out_valid=0 and all control outputs 0.
  - out_rs1/rs2/rd/funct3=0, out_imm=0, out_pc=0, out_aluOp=0, out_illegal=0.
  - stall_cnt=0, in_ready=0 during reset.
- Reset mid-transfer discards the held bundle. No partial state survives.
- Simultaneous flush and hazard: flush wins, and stall_cnt does not increment.

## Configuration
- DECODE_MULDIV_EN defined: OP with funct7=0000001 decodes the M extension as aluOp = {1'b1, 1'b0, funct3}, i.e. mul 10000 through remu 10111. Legal, regWrite=1.
- DECODE_MULDIV_EN undefined: those encodings are illegal (out_illegal=1). aluOp[4] is constant 0.

## Test plan
- Reset held 2 cycles, then `addi x5,x0,-3` (0xFFD00293): the next cycle gives out_valid=1, aluOp=00000, imm=0xFFFFFFFD, rd=5, regWrite=1, aluSrc=0.
- Back-to-back add/sub/xor/sra with out_ready=1: one output per cycle, aluOp 00000/00001/01010/00111 in order.
- `lw x6,0(x1)` then `add x7,x6,x2`: exactly one bubble, stall_cnt=1, then add is emitted. With rd=x0 for the load, no bubble occurs.
- out_ready=0 for 3 cycles with in_valid=1: bundle unchanged, in_ready=0, no instruction lost after release.
- flush asserted in the cycle a `jal` is accepted: next cycle out_valid=0, and the following instruction decodes normally.
- `mul x1,x2,x3` (0x023100B3): aluOp=10000 with DECODE_MULDIV_EN; out_illegal=1 and regWrite=0 without it.
